// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched uops, snoops the CDB to wake
// pending operands, and issues the lowest-index fully-ready entry to one FU.
module reservation_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OP_W  = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            dispatch_valid,
    output logic            dispatch_ready,
    input  logic [OP_W-1:0] dispatch_op,
    input  logic [5:0]      dispatch_dest_tag,
    input  logic [32:0]     dispatch_src1,
    input  logic [32:0]     dispatch_src2,
    input  logic            cdb_valid,
    input  logic [5:0]      cdb_tag,
    input  logic [31:0]     cdb_data,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [OP_W-1:0] issue_op,
    output logic [5:0]      issue_dest_tag,
    output logic [31:0]     issue_src1,
    output logic [31:0]     issue_src2,
    output logic [3:0]      occupancy
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [OP_W-1:0]   op_q      [DEPTH];
    logic [OP_W-1:0]   op_d      [DEPTH];
    logic [TAG_W-1:0]  dest_q    [DEPTH];
    logic [TAG_W-1:0]  dest_d    [DEPTH];
    logic [DEPTH-1:0]  s1_rdy_q, s1_rdy_d;
    logic [DEPTH-1:0]  s2_rdy_q, s2_rdy_d;
    logic [DATA_W-1:0] s1_data_q [DEPTH];
    logic [DATA_W-1:0] s1_data_d [DEPTH];
    logic [DATA_W-1:0] s2_data_q [DEPTH];
    logic [DATA_W-1:0] s2_data_d [DEPTH];
    logic [TAG_W-1:0]  s1_tag_q  [DEPTH];
    logic [TAG_W-1:0]  s1_tag_d  [DEPTH];
    logic [TAG_W-1:0]  s2_tag_q  [DEPTH];
    logic [TAG_W-1:0]  s2_tag_d  [DEPTH];
    logic [CNT_W-1:0]  occ_q, occ_d;

    logic [DEPTH-1:0]  issuable;
    logic [IDX_W-1:0]  free_idx;
    logic              free_found;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;
    logic              dispatch_fire;
    logic              issue_fire;

    assign issuable       = valid_q & s1_rdy_q & s2_rdy_q;
    assign dispatch_ready = (occ_q < CNT_W'(DEPTH));
    assign dispatch_fire  = dispatch_valid && dispatch_ready;
    assign issue_valid    = sel_found;
    assign issue_fire     = sel_found && issue_ready;
    assign occupancy      = occ_q;

    // Lowest-index free slot for dispatch
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Fixed-priority select of the lowest-index issuable entry
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_found && issuable[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Issue payload, forced to zero when nothing is presented
    always_comb begin
        issue_op       = '0;
        issue_dest_tag = '0;
        issue_src1     = '0;
        issue_src2     = '0;
        if (sel_found) begin
            issue_op       = op_q[sel_idx];
            issue_dest_tag = dest_q[sel_idx];
            issue_src1     = s1_data_q[sel_idx];
            issue_src2     = s2_data_q[sel_idx];
        end
    end

    // Next-state: wakeup, issue retire, dispatch write; flush squashes all
    always_comb begin
        valid_d   = valid_q;
        op_d      = op_q;
        dest_d    = dest_q;
        s1_rdy_d  = s1_rdy_q;
        s2_rdy_d  = s2_rdy_q;
        s1_data_d = s1_data_q;
        s2_data_d = s2_data_q;
        s1_tag_d  = s1_tag_q;
        s2_tag_d  = s2_tag_q;
        occ_d     = occ_q;

        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
        end else begin
            // CDB wakeup of pending sources in valid entries
            if (cdb_valid) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && !s1_rdy_q[i] && (s1_tag_q[i] == cdb_tag)) begin
                        s1_rdy_d[i]  = 1'b1;
                        s1_data_d[i] = cdb_data;
                    end
                    if (valid_q[i] && !s2_rdy_q[i] && (s2_tag_q[i] == cdb_tag)) begin
                        s2_rdy_d[i]  = 1'b1;
                        s2_data_d[i] = cdb_data;
                    end
                end
            end

            if (issue_fire) begin
                valid_d[sel_idx] = 1'b0;
            end

            // The free slot is never the issuing slot, so these cannot collide
            if (dispatch_fire) begin
                valid_d[free_idx]   = 1'b1;
                op_d[free_idx]      = dispatch_op;
                dest_d[free_idx]    = dispatch_dest_tag;
                s1_tag_d[free_idx]  = dispatch_src1[TAG_W-1:0];
                s2_tag_d[free_idx]  = dispatch_src2[TAG_W-1:0];
                s1_rdy_d[free_idx]  = dispatch_src1[32] ||
                                      (cdb_valid && (cdb_tag == dispatch_src1[TAG_W-1:0]));
                s2_rdy_d[free_idx]  = dispatch_src2[32] ||
                                      (cdb_valid && (cdb_tag == dispatch_src2[TAG_W-1:0]));
                s1_data_d[free_idx] = dispatch_src1[32] ? dispatch_src1[DATA_W-1:0] : cdb_data;
                s2_data_d[free_idx] = dispatch_src2[32] ? dispatch_src2[DATA_W-1:0] : cdb_data;
            end

            occ_d = occ_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            occ_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                op_q[i]      <= '0;
                dest_q[i]    <= '0;
                s1_data_q[i] <= '0;
                s2_data_q[i] <= '0;
                s1_tag_q[i]  <= '0;
                s2_tag_q[i]  <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            s1_rdy_q  <= s1_rdy_d;
            s2_rdy_q  <= s2_rdy_d;
            occ_q     <= occ_d;
            op_q      <= op_d;
            dest_q    <= dest_d;
            s1_data_q <= s1_data_d;
            s2_data_q <= s2_data_d;
            s1_tag_q  <= s1_tag_d;
            s2_tag_q  <= s2_tag_d;
        end
    end

endmodule
